// File: rtl/voice_allocator.sv
// voice_allocator: shares a pool of VOICES notebank voices among key-on/key-off
// events. Each event is accepted in IDLE, resolved to a target voice in DECIDE,
// and its one-cycle note_on/note_off/drop pulse is visible during ISSUE.
// Voice lifecycle FREE -> HELD -> RELEASE -> FREE follows the events and the
// per-voice voice_done pulse.
//
// Optional feature: define VOICE_STEAL_EN so that a key-on finding no match
// and no FREE voice steals the oldest RELEASE voice (or, if there is none,
// the oldest HELD voice). Without it, such a key-on is dropped.
//
// Ports:
//   clk, rst      slow audio clock, asynchronous active-high reset
//   ev_valid/ev_ready, ev_on, ev_key, ev_period   note event handshake and payload
//   voice_on, voice_off    one-hot one-cycle pulses per voice
//   voice_period           registered period per voice, voice i at [i*PERIOD_W +: PERIOD_W]
//   voice_done             per-voice end-of-release pulse from the envelope
//   active                 voice i is not FREE
//   ev_drop                accepted event was not served
module voice_allocator #(
   parameter int unsigned VOICES   = 4,
   parameter int unsigned KEY_W    = 7,
   parameter int unsigned PERIOD_W = 23,
   parameter int unsigned AGE_W    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ev_valid,
   output logic                       ev_ready,
   input  logic                       ev_on,
   input  logic [KEY_W-1:0]           ev_key,
   input  logic [PERIOD_W-1:0]        ev_period,
   output logic [VOICES-1:0]          voice_on,
   output logic [VOICES-1:0]          voice_off,
   output logic [VOICES*PERIOD_W-1:0] voice_period,
   input  logic [VOICES-1:0]          voice_done,
   output logic [VOICES-1:0]          active,
   output logic                       ev_drop
);
   localparam int unsigned IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_ISSUE} state_t;
   typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vstate_t;

   state_t                state_q, state_d;
   logic                  lat_on;
   logic [KEY_W-1:0]      lat_key;
   logic [PERIOD_W-1:0]   lat_period;

   vstate_t               vst_q [VOICES];
   vstate_t               vst_d [VOICES];
   logic [KEY_W-1:0]      key_q [VOICES];
   logic [KEY_W-1:0]      key_d [VOICES];
   logic [AGE_W-1:0]      age_q [VOICES];
   logic [AGE_W-1:0]      age_d [VOICES];

   logic [VOICES*PERIOD_W-1:0] period_d;
   logic [VOICES-1:0]     on_d, off_d, active_d;
   logic                  drop_d, ready_d;

   logic                  match_hit, free_hit, tgt_hit;
   logic [IDX_W-1:0]      match_idx, free_idx, tgt_idx;
`ifdef VOICE_STEAL_EN
   logic                  rel_hit, held_hit;
   logic [IDX_W-1:0]      rel_idx, held_idx;
   logic [AGE_W-1:0]      rel_age, held_age;
`endif

   // Target voice selection for the latched event; ties go to the lowest index.
   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      free_hit  = 1'b0;
      free_idx  = '0;
`ifdef VOICE_STEAL_EN
      rel_hit   = 1'b0;
      rel_idx   = '0;
      rel_age   = '0;
      held_hit  = 1'b0;
      held_idx  = '0;
      held_age  = '0;
`endif
      for (int unsigned i = 0; i < VOICES; i++) begin
         if (!match_hit && vst_q[i] == V_HELD && key_q[i] == lat_key) begin
            match_hit = 1'b1;
            match_idx = IDX_W'(i);
         end
         if (!free_hit && vst_q[i] == V_FREE) begin
            free_hit = 1'b1;
            free_idx = IDX_W'(i);
         end
`ifdef VOICE_STEAL_EN
         // strict greater-than keeps the lowest index on equal ages
         if (vst_q[i] == V_REL && (!rel_hit || age_q[i] > rel_age)) begin
            rel_hit = 1'b1;
            rel_idx = IDX_W'(i);
            rel_age = age_q[i];
         end
         if (vst_q[i] == V_HELD && (!held_hit || age_q[i] > held_age)) begin
            held_hit = 1'b1;
            held_idx = IDX_W'(i);
            held_age = age_q[i];
         end
`endif
      end

      tgt_hit = 1'b0;
      tgt_idx = '0;
      if (match_hit) begin
         tgt_hit = 1'b1;
         tgt_idx = match_idx;
      end else if (lat_on && free_hit) begin
         tgt_hit = 1'b1;
         tgt_idx = free_idx;
      end
`ifdef VOICE_STEAL_EN
      else if (lat_on && rel_hit) begin
         tgt_hit = 1'b1;
         tgt_idx = rel_idx;
      end else if (lat_on && held_hit) begin
         tgt_hit = 1'b1;
         tgt_idx = held_idx;
      end
`endif
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      vst_d    = vst_q;
      key_d    = key_q;
      age_d    = age_q;
      period_d = voice_period;
      on_d     = '0;
      off_d    = '0;
      drop_d   = 1'b0;
      active_d = '0;

      for (int unsigned i = 0; i < VOICES; i++) begin
         if (voice_done[i] && vst_q[i] == V_REL) begin
            vst_d[i] = V_FREE;
            age_d[i] = '0;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (ev_valid) state_d = S_DECIDE;
         end
         S_DECIDE: begin
            state_d = S_ISSUE;
            if (!tgt_hit) begin
               drop_d = 1'b1;
            end else begin
               for (int unsigned i = 0; i < VOICES; i++) begin
                  if (IDX_W'(i) == tgt_idx) begin
                     // key-on overrides a concurrent done on the same voice
                     if (lat_on) begin
                        vst_d[i] = V_HELD;
                        key_d[i] = lat_key;
                        age_d[i] = '0;
                        period_d[i*PERIOD_W +: PERIOD_W] = lat_period;
                        on_d[i]  = 1'b1;
                     end else begin
                        vst_d[i] = V_REL;
                        off_d[i] = 1'b1;
                     end
                  end else if (lat_on && vst_d[i] != V_FREE && age_d[i] != '1) begin
                     age_d[i] = age_d[i] + AGE_W'(1);
                  end
               end
            end
         end
         S_ISSUE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      for (int unsigned i = 0; i < VOICES; i++) begin
         active_d[i] = (vst_d[i] != V_FREE);
      end
      ready_d = (state_d == S_IDLE);
   end

   // State, voice table and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         lat_on       <= 1'b0;
         lat_key      <= '0;
         lat_period   <= '0;
         for (int unsigned i = 0; i < VOICES; i++) begin
            vst_q[i] <= V_FREE;
            key_q[i] <= '0;
            age_q[i] <= '0;
         end
         voice_period <= '0;
         voice_on     <= '0;
         voice_off    <= '0;
         ev_drop      <= 1'b0;
         active       <= '0;
         ev_ready     <= 1'b1;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && ev_valid) begin
            lat_on     <= ev_on;
            lat_key    <= ev_key;
            lat_period <= ev_period;
         end
         vst_q        <= vst_d;
         key_q        <= key_d;
         age_q        <= age_d;
         voice_period <= period_d;
         voice_on     <= on_d;
         voice_off    <= off_d;
         ev_drop      <= drop_d;
         active       <= active_d;
         ev_ready     <= ready_d;
      end
   end
endmodule
